bit_selection_sequencer: RTL and testbench

BIT_SELECTION_SEQUENCER -- requirements
Module: bit_selection_sequencer

---
 rtl/bit_selection_sequencer_pkg.sv | 30 +++
 rtl/bit_selection_result_fifo.sv | 56 +++++
 rtl/bit_selection_sequencer.sv | 123 ++++++++++++
 tb/tb_bit_selection_sequencer.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/bit_selection_sequencer_pkg.sv
// Shared constants, FSM state type and helper functions for the bit-selection sequencer.
// The command encoding matches the downstream window selector's {shift_en, shift_m1} format.
package bit_selection_sequencer_pkg;

   localparam int DATA_W    = 16;
   localparam int CMD_W     = 4;
   localparam int OUT_W     = 8;
   localparam int MAX_SHIFT = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   function automatic logic [CMD_W-1:0] encode_cmd(input logic [3:0] shift);
      logic [2:0] m1;
      m1 = 3'(shift - 4'd1);
      return (shift == 4'd0) ? '0 : {1'b1, m1};
   endfunction

   // Windows past MAX_SHIFT would read beyond the word, so the request is clipped.
   function automatic logic [3:0] eff_count(input logic [3:0] off, input logic [3:0] cnt);
      logic [3:0] room;
      if (off > 4'(MAX_SHIFT)) return 4'd0;
      room = 4'(MAX_SHIFT + 1) - off;
      return (cnt < room) ? cnt : room;
   endfunction

endpackage

// File: rtl/bit_selection_result_fifo.sv
// Small circular result buffer carrying each selected window plus its last-of-request tag.
// A push into a full buffer is accepted when a pop happens in the same cycle.
module bit_selection_result_fifo #(
   parameter int DEPTH = 2,
   parameter int W     = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push_i,
   input  logic [W-1:0]               data_i,
   input  logic                       last_i,
   input  logic                       pop_i,
   output logic [W-1:0]               data_o,
   output logic                       last_o,
   output logic                       empty_o,
   output logic                       full_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [W:0]    mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q;
   logic [PW-1:0] rd_ptr_q;
   logic [CW-1:0] cnt_q;
   logic          do_push;
   logic          do_pop;

   function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign empty_o          = (cnt_q == '0);
   assign full_o           = (cnt_q == CW'(DEPTH));
   assign do_pop           = pop_i && !empty_o;
   assign do_push          = push_i && (!full_o || do_pop);
   assign {last_o, data_o} = mem_q[rd_ptr_q];
   assign count_o          = cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (do_push) wr_ptr_q <= ptr_next(wr_ptr_q);
         if (do_pop)  rd_ptr_q <= ptr_next(rd_ptr_q);
         cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= {last_i, data_i};
   end

endmodule

// File: rtl/bit_selection_sequencer.sv
// Slices a 16-bit word into consecutive 8-bit windows by driving an external
// one-cycle-latency selector, buffering its results with a last-window tag.
module bit_selection_sequencer
   import bit_selection_sequencer_pkg::*;
#(
   parameter int DATA_WIDTH     = DATA_W,
   parameter int COMMAND_WIDTH  = CMD_W,
   parameter int OUT_DATA_WIDTH = OUT_W,
   parameter int FIFO_DEPTH     = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      i_req_valid,
   output logic                      o_req_ready,
   input  logic [DATA_WIDTH-1:0]     i_req_data,
   input  logic [3:0]                i_req_offset,
   input  logic [3:0]                i_req_count,
   output logic                      o_sel_valid,
   output logic                      o_sel_en,
   output logic [DATA_WIDTH-1:0]     o_sel_data,
   output logic [COMMAND_WIDTH-1:0]  o_sel_cmd,
   input  logic                      i_sel_valid,
   input  logic [OUT_DATA_WIDTH-1:0] i_sel_data,
   output logic                      o_res_valid,
   input  logic                      i_res_ready,
   output logic [OUT_DATA_WIDTH-1:0] o_res_data,
   output logic                      o_res_last,
   output logic                      o_busy,
   output logic                      o_err_clip
);
   localparam int CW = $clog2(FIFO_DEPTH + 1);

   state_t                  state_q;
   logic [DATA_WIDTH-1:0]   data_q;
   logic [3:0]              shift_q;
   logic [3:0]              rem_q;
   logic [3:0]              out_q;
   logic                    tag_q;

   logic                    accept;
   logic                    issue;
   logic                    ret;
   logic                    pop;
   logic [3:0]              eff;
   logic [3:0]              credit;
   logic [CW-1:0]           fifo_cnt;
   logic                    fifo_empty;
   logic                    fifo_full;
   logic                    fifo_last;

   assign accept = (state_q == ST_IDLE) && i_req_valid;
   assign eff    = eff_count(i_req_offset, i_req_count);
   assign pop    = !fifo_empty && i_res_ready;
   assign ret    = i_sel_valid && (out_q != 4'd0);

   // A pop this cycle frees a slot before the next return lands, which keeps
   // the pipeline bubble-free while the consumer is ready.
   assign credit = out_q + 4'(fifo_cnt) - 4'(pop);
   assign issue  = (state_q == ST_ISSUE) && (rem_q != 4'd0) && (credit < 4'(FIFO_DEPTH));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         data_q  <= '0;
         shift_q <= '0;
         rem_q   <= '0;
         out_q   <= '0;
         tag_q   <= 1'b0;
      end else begin
         out_q <= out_q + 4'(issue) - 4'(ret);
         if (issue) begin
            tag_q   <= (rem_q == 4'd1);
            shift_q <= shift_q + 4'd1;
            rem_q   <= rem_q - 4'd1;
         end
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  data_q  <= i_req_data;
                  shift_q <= i_req_offset;
                  rem_q   <= eff;
                  if (eff != 4'd0) state_q <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (issue && (rem_q == 4'd1)) state_q <= ST_DRAIN;
            end
            ST_DRAIN: begin
               if (fifo_empty && (out_q == 4'd0)) state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   bit_selection_result_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (OUT_DATA_WIDTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (ret),
      .data_i  (i_sel_data),
      .last_i  (tag_q),
      .pop_i   (pop),
      .data_o  (o_res_data),
      .last_o  (fifo_last),
      .empty_o (fifo_empty),
      .full_o  (fifo_full),
      .count_o (fifo_cnt)
   );

   assign o_req_ready = (state_q == ST_IDLE);
   assign o_sel_valid = issue;
   assign o_sel_en    = issue;
   assign o_sel_cmd   = issue ? COMMAND_WIDTH'(encode_cmd(shift_q)) : '0;
   assign o_sel_data  = data_q;
   assign o_res_valid = !fifo_empty;
   assign o_res_last  = !fifo_empty && fifo_last;
   assign o_busy      = (state_q != ST_IDLE) || !fifo_empty;
   assign o_err_clip  = accept && (eff < i_req_count) && !fifo_full;

endmodule

// File: tb/tb_bit_selection_sequencer.sv
// Directed bench for bit_selection_sequencer with a behavioural one-cycle selector.
module tb_bit_selection_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_req_valid;
   logic        o_req_ready;
   logic [15:0] i_req_data;
   logic [3:0]  i_req_offset;
   logic [3:0]  i_req_count;
   logic        o_sel_valid;
   logic        o_sel_en;
   logic [15:0] o_sel_data;
   logic [3:0]  o_sel_cmd;
   logic        i_sel_valid;
   logic [7:0]  i_sel_data;
   logic        o_res_valid;
   logic        i_res_ready;
   logic [7:0]  o_res_data;
   logic        o_res_last;
   logic        o_busy;
   logic        o_err_clip;

   int pass_cnt  = 0;
   int check_cnt = 0;

   logic [7:0] rd [16];
   logic       rl [16];
   int         rc [16];
   logic [3:0] cmds [16];
   int         nres, ncmd, hold_issues;
   logic       clip_seen, acc_ready, ready_never_low, done;

   always #5 clk = ~clk;

   bit_selection_sequencer dut (
      .clk          (clk),
      .rst          (rst),
      .i_req_valid  (i_req_valid),
      .o_req_ready  (o_req_ready),
      .i_req_data   (i_req_data),
      .i_req_offset (i_req_offset),
      .i_req_count  (i_req_count),
      .o_sel_valid  (o_sel_valid),
      .o_sel_en     (o_sel_en),
      .o_sel_data   (o_sel_data),
      .o_sel_cmd    (o_sel_cmd),
      .i_sel_valid  (i_sel_valid),
      .i_sel_data   (i_sel_data),
      .o_res_valid  (o_res_valid),
      .i_res_ready  (i_res_ready),
      .o_res_data   (o_res_data),
      .o_res_last   (o_res_last),
      .o_busy       (o_busy),
      .o_err_clip   (o_err_clip)
   );

   // Selector model: one-cycle latency, keeps running through DUT resets.
   function automatic logic [7:0] sel_model(input logic [15:0] d, input logic [3:0] c);
      logic [15:0] t;
      int s;
      s = c[3] ? int'(c[2:0]) + 1 : 0;
      t = d >> s;
      return t[7:0];
   endfunction

   logic       sel_v = 1'b0;
   logic [7:0] sel_d = 8'h00;
   always @(posedge clk) begin
      sel_v <= o_sel_valid & o_sel_en;
      sel_d <= sel_model(o_sel_data, o_sel_cmd);
   end
   assign i_sel_valid = sel_v;
   assign i_sel_data  = sel_d;

   // Runs one request and records issues/results; hold = cycles of i_res_ready low.
   task automatic do_req(input logic [15:0] d, input logic [3:0] off,
                         input logic [3:0] cnt, input int hold);
      nres = 0; ncmd = 0; hold_issues = 0; ready_never_low = 1'b1; done = 1'b0;
      @(negedge clk);
      i_req_valid = 1'b1; i_req_data = d; i_req_offset = off; i_req_count = cnt;
      i_res_ready = (hold > 0) ? 1'b0 : 1'b1;
      #1;
      clip_seen = o_err_clip;
      acc_ready = o_req_ready;
      @(negedge clk);
      i_req_valid = 1'b0;
      for (int c = 1; c <= 80; c++) begin
         i_res_ready = (c <= hold) ? 1'b0 : 1'b1;
         #1;
         if (o_sel_valid) begin
            if (ncmd < 16) cmds[ncmd] = o_sel_cmd;
            ncmd++;
            if (c <= hold) hold_issues++;
         end
         if (o_res_valid && i_res_ready) begin
            if (nres < 16) begin rd[nres] = o_res_data; rl[nres] = o_res_last; rc[nres] = c; end
            nres++;
         end
         if (!o_req_ready) ready_never_low = 1'b0;
         if (c >= 3 && !o_busy) begin done = 1'b1; break; end
         @(negedge clk);
      end
      check_cnt++;
      if (done !== 1'b1) $display("FAIL req_timeout: completed=%b want 1", done); else pass_cnt++;
   endtask

   task automatic test_reset();
      rst = 1'b1; i_req_valid = 1'b0; i_req_data = '0; i_req_offset = '0;
      i_req_count = '0; i_res_ready = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      check_cnt++; if (o_req_ready !== 1'b1) $display("FAIL rst_req_ready: got %b want 1", o_req_ready); else pass_cnt++;
      check_cnt++; if (o_sel_valid !== 1'b0) $display("FAIL rst_sel_valid: got %b want 0", o_sel_valid); else pass_cnt++;
      check_cnt++; if (o_sel_en !== 1'b0) $display("FAIL rst_sel_en: got %b want 0", o_sel_en); else pass_cnt++;
      check_cnt++; if (o_sel_cmd !== 4'h0) $display("FAIL rst_sel_cmd: got %h want 0", o_sel_cmd); else pass_cnt++;
      check_cnt++; if (o_sel_data !== 16'h0) $display("FAIL rst_sel_data: got %h want 0", o_sel_data); else pass_cnt++;
      check_cnt++; if (o_res_valid !== 1'b0) $display("FAIL rst_res_valid: got %b want 0", o_res_valid); else pass_cnt++;
      check_cnt++; if (o_res_last !== 1'b0) $display("FAIL rst_res_last: got %b want 0", o_res_last); else pass_cnt++;
      check_cnt++; if (o_busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", o_busy); else pass_cnt++;
      check_cnt++; if (o_err_clip !== 1'b0) $display("FAIL rst_err_clip: got %b want 0", o_err_clip); else pass_cnt++;
      rst = 1'b0;
   endtask

   task automatic test_full_sweep();
      logic [7:0] exp_d [8];
      exp_d = '{8'h21, 8'h10, 8'h88, 8'h44, 8'h22, 8'h91, 8'h48, 8'hA4};
      do_req(16'hA442, 4'd1, 4'd8, 0);
      check_cnt++; if (acc_ready !== 1'b1) $display("FAIL sweep_accept_ready: got %b want 1", acc_ready); else pass_cnt++;
      check_cnt++; if (clip_seen !== 1'b0) $display("FAIL sweep_clip: got %b want 0", clip_seen); else pass_cnt++;
      check_cnt++; if (ncmd != 8) $display("FAIL sweep_ncmd: got %0d want 8", ncmd); else pass_cnt++;
      check_cnt++; if (nres != 8) $display("FAIL sweep_nres: got %0d want 8", nres); else pass_cnt++;
      for (int k = 0; k < 8 && k < nres && k < ncmd; k++) begin
         check_cnt++; if (cmds[k] !== 4'(8 + k)) $display("FAIL sweep_cmd[%0d]: got %h want %h", k, cmds[k], 4'(8 + k)); else pass_cnt++;
         check_cnt++; if (rd[k] !== exp_d[k]) $display("FAIL sweep_data[%0d]: got %h want %h", k, rd[k], exp_d[k]); else pass_cnt++;
         check_cnt++; if (rl[k] !== (k == 7)) $display("FAIL sweep_last[%0d]: got %b want %b", k, rl[k], (k == 7)); else pass_cnt++;
         check_cnt++; if (rc[k] != 3 + k) $display("FAIL sweep_cycle[%0d]: got %0d want %0d", k, rc[k], 3 + k); else pass_cnt++;
      end
   endtask

   task automatic test_single();
      do_req(16'hA442, 4'd0, 4'd1, 0);
      check_cnt++; if (ncmd != 1 || cmds[0] !== 4'h0) $display("FAIL single_cmd: got n=%0d cmd=%h want n=1 cmd=0", ncmd, cmds[0]); else pass_cnt++;
      check_cnt++; if (nres != 1 || rd[0] !== 8'h42) $display("FAIL single_data: got n=%0d d=%h want n=1 d=42", nres, rd[0]); else pass_cnt++;
      check_cnt++; if (rl[0] !== 1'b1) $display("FAIL single_last: got %b want 1", rl[0]); else pass_cnt++;
      check_cnt++; if (o_busy !== 1'b0) $display("FAIL single_busy: got %b want 0", o_busy); else pass_cnt++;
      check_cnt++; if (o_req_ready !== 1'b1) $display("FAIL single_idle_ready: got %b want 1", o_req_ready); else pass_cnt++;
   endtask

   task automatic test_clip();
      logic [7:0] exp_d [3];
      exp_d = '{8'h91, 8'h48, 8'hA4};
      do_req(16'hA442, 4'd6, 4'd5, 0);
      check_cnt++; if (clip_seen !== 1'b1) $display("FAIL clip_pulse: got %b want 1", clip_seen); else pass_cnt++;
      check_cnt++; if (nres != 3) $display("FAIL clip_nres: got %0d want 3", nres); else pass_cnt++;
      for (int k = 0; k < 3 && k < nres && k < ncmd; k++) begin
         check_cnt++; if (cmds[k] !== 4'(13 + k)) $display("FAIL clip_cmd[%0d]: got %h want %h", k, cmds[k], 4'(13 + k)); else pass_cnt++;
         check_cnt++; if (rd[k] !== exp_d[k]) $display("FAIL clip_data[%0d]: got %h want %h", k, rd[k], exp_d[k]); else pass_cnt++;
         check_cnt++; if (rl[k] !== (k == 2)) $display("FAIL clip_last[%0d]: got %b want %b", k, rl[k], (k == 2)); else pass_cnt++;
      end
      do_req(16'hA442, 4'd9, 4'd3, 0);
      check_cnt++; if (clip_seen !== 1'b1) $display("FAIL clip_off9_pulse: got %b want 1", clip_seen); else pass_cnt++;
      check_cnt++; if (ncmd != 0 || nres != 0) $display("FAIL clip_off9_empty: got cmds=%0d res=%0d want 0/0", ncmd, nres); else pass_cnt++;
   endtask

   task automatic test_backpressure();
      logic [7:0] exp_d [9];
      exp_d = '{8'h42, 8'h21, 8'h10, 8'h88, 8'h44, 8'h22, 8'h91, 8'h48, 8'hA4};
      do_req(16'hA442, 4'd0, 4'd9, 5);
      check_cnt++; if (hold_issues != 2) $display("FAIL bp_issues_while_held: got %0d want 2", hold_issues); else pass_cnt++;
      check_cnt++; if (clip_seen !== 1'b0) $display("FAIL bp_clip: got %b want 0", clip_seen); else pass_cnt++;
      check_cnt++; if (nres != 9) $display("FAIL bp_nres: got %0d want 9", nres); else pass_cnt++;
      for (int k = 0; k < 9 && k < nres; k++) begin
         check_cnt++; if (rd[k] !== exp_d[k]) $display("FAIL bp_data[%0d]: got %h want %h", k, rd[k], exp_d[k]); else pass_cnt++;
         check_cnt++; if (rl[k] !== (k == 8)) $display("FAIL bp_last[%0d]: got %b want %b", k, rl[k], (k == 8)); else pass_cnt++;
      end
   endtask

   task automatic test_zero_count();
      do_req(16'hA442, 4'd0, 4'd0, 0);
      check_cnt++; if (ncmd != 0) $display("FAIL zero_issues: got %0d want 0", ncmd); else pass_cnt++;
      check_cnt++; if (nres != 0) $display("FAIL zero_results: got %0d want 0", nres); else pass_cnt++;
      check_cnt++; if (ready_never_low !== 1'b1) $display("FAIL zero_ready_held: got %b want 1", ready_never_low); else pass_cnt++;
      check_cnt++; if (clip_seen !== 1'b0) $display("FAIL zero_clip: got %b want 0", clip_seen); else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      i_req_valid = 1'b1; i_req_data = 16'hA442; i_req_offset = 4'd0; i_req_count = 4'd9;
      i_res_ready = 1'b1;
      @(negedge clk);
      i_req_valid = 1'b0;
      repeat (3) @(negedge clk);
      check_cnt++; if (o_res_valid !== 1'b1 || i_sel_valid !== 1'b1) $display("FAIL mid_precondition: got res_valid=%b sel_ret=%b want 1/1", o_res_valid, i_sel_valid); else pass_cnt++;
      rst = 1'b1;
      #1;
      check_cnt++; if (o_req_ready !== 1'b1) $display("FAIL mid_req_ready: got %b want 1", o_req_ready); else pass_cnt++;
      check_cnt++; if (o_sel_valid !== 1'b0 || o_sel_en !== 1'b0) $display("FAIL mid_sel_valid_en: got %b%b want 00", o_sel_valid, o_sel_en); else pass_cnt++;
      check_cnt++; if (o_sel_cmd !== 4'h0 || o_sel_data !== 16'h0) $display("FAIL mid_sel_cmd_data: got %h/%h want 0/0", o_sel_cmd, o_sel_data); else pass_cnt++;
      check_cnt++; if (o_res_valid !== 1'b0 || o_res_last !== 1'b0) $display("FAIL mid_res: got valid=%b last=%b want 0/0", o_res_valid, o_res_last); else pass_cnt++;
      check_cnt++; if (o_busy !== 1'b0 || o_err_clip !== 1'b0) $display("FAIL mid_busy_clip: got %b/%b want 0/0", o_busy, o_err_clip); else pass_cnt++;
      #1;
      rst = 1'b0;
      @(negedge clk);
      #1;
      check_cnt++; if (o_res_valid !== 1'b0 || o_busy !== 1'b0) $display("FAIL mid_stale_return: got valid=%b busy=%b want 0/0", o_res_valid, o_busy); else pass_cnt++;
      do_req(16'h8001, 4'd7, 4'd2, 0);
      check_cnt++; if (nres != 2) $display("FAIL post_rst_nres: got %0d want 2", nres); else pass_cnt++;
      check_cnt++; if (rd[0] !== 8'h00 || rd[1] !== 8'h80) $display("FAIL post_rst_data: got %h %h want 00 80", rd[0], rd[1]); else pass_cnt++;
      check_cnt++; if (rl[0] !== 1'b0 || rl[1] !== 1'b1) $display("FAIL post_rst_last: got %b%b want 01", rl[0], rl[1]); else pass_cnt++;
      check_cnt++; if (cmds[0] !== 4'hE || cmds[1] !== 4'hF) $display("FAIL post_rst_cmd: got %h %h want E F", cmds[0], cmds[1]); else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_full_sweep();
      test_single();
      test_clip();
      test_backpressure();
      test_zero_count();
      test_reset_mid();
      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
